smalldiv_lut_stage: RTL and testbench

- One radix-2^DIGIT_WIDTH digit step of a small-constant divider.
- Divides the concatenation {last_remainder, dividend_digit} by the constant DIVIDER_VALUE, producing one quotient digit and a new partial remainder.
- Stages chain MSB-first: remainder out feeds the next lower stage's last_remainder.
- Implemented as an elaboration-time lookup table with an optional output register.

---
 rtl/smalldiv_pkg.sv | 27 ++
 rtl/smalldiv_lut_rom.sv | 37 +++
 rtl/smalldiv_lut_stage.sv | 83 ++++++++
 tb/tb_smalldiv_lut_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/smalldiv_pkg.sv
// Shared helpers for the small-constant divider: table-entry generation used by the
// lookup ROM at elaboration time and by reference models.
package smalldiv_pkg;

  localparam int unsigned ENTRY_MAX_W = 64;

  // Returns {overflow, quotient[digit_width-1:0], remainder[divider_width-1:0]}, LSB-aligned.
  function automatic logic [ENTRY_MAX_W-1:0] div_entry(
    input longint unsigned n,
    input int unsigned     divider,
    input int unsigned     digit_width,
    input int unsigned     divider_width
  );
    longint unsigned q;
    longint unsigned r;
    longint unsigned q_mask;
    logic            ovf;
    q      = n / 64'(divider);
    r      = n % 64'(divider);
    q_mask = (64'(1) << digit_width) - 64'(1);
    ovf    = (q >> digit_width) != 64'd0;
    return (64'(ovf) << (digit_width + divider_width))
         | ((q & q_mask) << divider_width)
         | r;
  endfunction

endpackage

// File: rtl/smalldiv_lut_rom.sv
// Purely combinational divide-by-constant digit table, addressed by
// {last_remainder, dividend_digit}; every entry is fixed at elaboration.
module smalldiv_lut_rom
  import smalldiv_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH   = 3,
  parameter int unsigned DIVIDER_VALUE = 5,
  parameter int unsigned DIVIDER_WIDTH = $clog2(DIVIDER_VALUE)
) (
  input  logic [DIGIT_WIDTH-1:0]   dividend_digit,
  input  logic [DIVIDER_WIDTH-1:0] last_remainder,
  output logic [DIGIT_WIDTH-1:0]   quotient_c,
  output logic [DIVIDER_WIDTH-1:0] remainder_c,
  output logic                     overflow_c
);

  localparam int unsigned ADDR_W  = DIVIDER_WIDTH + DIGIT_WIDTH;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned ENTRY_W = 1 + DIGIT_WIDTH + DIVIDER_WIDTH;

  logic [ENTRY_W-1:0] table_w [DEPTH];
  logic [ADDR_W-1:0]  addr_c;
  logic [ENTRY_W-1:0] entry_c;

  for (genvar a = 0; a < int'(DEPTH); a++) begin : g_entry
    localparam logic [ENTRY_MAX_W-1:0] FULL =
      div_entry(64'(a), DIVIDER_VALUE, DIGIT_WIDTH, DIVIDER_WIDTH);
    assign table_w[a] = FULL[ENTRY_W-1:0];
  end

  assign addr_c      = {last_remainder, dividend_digit};
  assign entry_c     = table_w[addr_c];
  assign remainder_c = entry_c[DIVIDER_WIDTH-1:0];
  assign quotient_c  = entry_c[DIVIDER_WIDTH +: DIGIT_WIDTH];
  assign overflow_c  = entry_c[ENTRY_W-1];

endmodule

// File: rtl/smalldiv_lut_stage.sv
// One radix-2^DIGIT_WIDTH digit step of a small-constant divider: lookup table plus an
// optional reset/enable output register.
module smalldiv_lut_stage
  import smalldiv_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH   = 3,
  parameter int unsigned DIVIDER_VALUE = 5,
  parameter int unsigned DIVIDER_WIDTH = $clog2(DIVIDER_VALUE),
  parameter bit          REGISTER_OUT  = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DIGIT_WIDTH-1:0]   dividend_digit,
  input  logic [DIVIDER_WIDTH-1:0] last_remainder,
  output logic [DIGIT_WIDTH-1:0]   quotient,
  output logic [DIVIDER_WIDTH-1:0] remainder,
  output logic                     overflow
);

  if (DIVIDER_VALUE < 2 || DIGIT_WIDTH < 1 || $clog2(DIVIDER_VALUE) > DIVIDER_WIDTH) begin : g_bad_params
    $fatal(1, "smalldiv_lut_stage: illegal parameters (need DIVIDER_VALUE>=2, DIGIT_WIDTH>=1, DIVIDER_WIDTH>=clog2(DIVIDER_VALUE))");
  end

  logic [DIGIT_WIDTH-1:0]   rom_quotient_c;
  logic [DIVIDER_WIDTH-1:0] rom_remainder_c;
  logic                     rom_overflow_c;

  smalldiv_lut_rom #(
    .DIGIT_WIDTH   (DIGIT_WIDTH),
    .DIVIDER_VALUE (DIVIDER_VALUE),
    .DIVIDER_WIDTH (DIVIDER_WIDTH)
  ) u_rom (
    .dividend_digit (dividend_digit),
    .last_remainder (last_remainder),
    .quotient_c     (rom_quotient_c),
    .remainder_c    (rom_remainder_c),
    .overflow_c     (rom_overflow_c)
  );

  if (REGISTER_OUT) begin : g_reg
    logic [DIGIT_WIDTH-1:0]   quotient_q,  quotient_d;
    logic [DIVIDER_WIDTH-1:0] remainder_q, remainder_d;
    logic                     overflow_q,  overflow_d;

    // Load on enable, otherwise hold.
    always_comb begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      overflow_d  = overflow_q;
      if (enable) begin
        quotient_d  = rom_quotient_c;
        remainder_d = rom_remainder_c;
        overflow_d  = rom_overflow_c;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        quotient_q  <= '0;
        remainder_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        quotient_q  <= quotient_d;
        remainder_q <= remainder_d;
        overflow_q  <= overflow_d;
      end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;
  end else begin : g_comb
    // Control inputs have no function without the output register.
    logic unused_ctrl;
    assign unused_ctrl = ^{clock, reset, enable};

    assign quotient  = rom_quotient_c;
    assign remainder = rom_remainder_c;
    assign overflow  = rom_overflow_c;
  end

endmodule

// File: tb/tb_smalldiv_lut_stage.sv
// Directed and exhaustive checks of smalldiv_lut_stage in registered (V=5/D=3, V=3/D=4)
// and combinational configurations, against an independent arithmetic model.
module tb_smalldiv_lut_stage;

  typedef struct {
    int    q;
    int    r;
    bit    ovf;
    string tag;
  } exp_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // DUT A: V=5, D=3, W=3, registered
  logic       en_a;
  logic [2:0] d_a, r_a, q_a, rem_a;
  logic       ovf_a;
  // DUT B: V=3, D=4, W=2, registered
  logic       en_b;
  logic [3:0] d_b, q_b;
  logic [1:0] r_b, rem_b;
  logic       ovf_b;
  // DUT C: V=5, D=3, W=3, combinational
  logic       reset_c, en_c;
  logic [2:0] d_c, r_c, q_c, rem_c;
  logic       ovf_c;

  smalldiv_lut_stage #(.DIGIT_WIDTH(3), .DIVIDER_VALUE(5), .DIVIDER_WIDTH(3), .REGISTER_OUT(1'b1)) u_a (
    .clock(clock), .reset(reset), .enable(en_a), .dividend_digit(d_a), .last_remainder(r_a),
    .quotient(q_a), .remainder(rem_a), .overflow(ovf_a));

  smalldiv_lut_stage #(.DIGIT_WIDTH(4), .DIVIDER_VALUE(3), .DIVIDER_WIDTH(2), .REGISTER_OUT(1'b1)) u_b (
    .clock(clock), .reset(reset), .enable(en_b), .dividend_digit(d_b), .last_remainder(r_b),
    .quotient(q_b), .remainder(rem_b), .overflow(ovf_b));

  smalldiv_lut_stage #(.DIGIT_WIDTH(3), .DIVIDER_VALUE(5), .DIVIDER_WIDTH(3), .REGISTER_OUT(1'b0)) u_c (
    .clock(clock), .reset(reset_c), .enable(en_c), .dividend_digit(d_c), .last_remainder(r_c),
    .quotient(q_c), .remainder(rem_c), .overflow(ovf_c));

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t last_a, last_b;

  function automatic exp_t model(int v, int dw, int r, int d, string tag);
    exp_t e;
    int   n, qf;
    n     = r * (1 << dw) + d;
    qf    = n / v;
    e.q   = qf % (1 << dw);
    e.r   = n % v;
    e.ovf = (qf >= (1 << dw));
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t mk(int q, int r, bit ovf, string tag);
    exp_t e;
    e.q = q; e.r = r; e.ovf = ovf; e.tag = tag;
    return e;
  endfunction

  // Drive one cycle on DUT A, push what the register should hold, pop and compare after the edge.
  task automatic step_a(input logic rst, input logic en, input int r, input int d, input exp_t e);
    exp_t want, got_exp;
    logic [6:0] got, exp_v;
    reset = rst; en_a = en; r_a = 3'(r); d_a = 3'(d);
    if (rst)     want = mk(0, 0, 1'b0, e.tag);
    else if (en) want = e;
    else begin   want = last_a; want.tag = e.tag; end
    last_a = want;
    sb_a.push_back(want);
    @(posedge clock); #1;
    got_exp = sb_a.pop_front();
    got   = {ovf_a, q_a, rem_a};
    exp_v = {got_exp.ovf, 3'(got_exp.q), 3'(got_exp.r)};
    n_cmp++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got q=%0d rem=%0d ovf=%0d, expected q=%0d rem=%0d ovf=%0d",
             got_exp.tag, q_a, rem_a, ovf_a, got_exp.q, got_exp.r, got_exp.ovf);
    end
  endtask

  task automatic step_b(input logic rst, input logic en, input int r, input int d, input exp_t e);
    exp_t want, got_exp;
    logic [6:0] got, exp_v;
    reset = rst; en_b = en; r_b = 2'(r); d_b = 4'(d);
    if (rst)     want = mk(0, 0, 1'b0, e.tag);
    else if (en) want = e;
    else begin   want = last_b; want.tag = e.tag; end
    last_b = want;
    sb_b.push_back(want);
    @(posedge clock); #1;
    got_exp = sb_b.pop_front();
    got   = {ovf_b, q_b, rem_b};
    exp_v = {got_exp.ovf, 4'(got_exp.q), 2'(got_exp.r)};
    n_cmp++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got q=%0d rem=%0d ovf=%0d, expected q=%0d rem=%0d ovf=%0d",
             got_exp.tag, q_b, rem_b, ovf_b, got_exp.q, got_exp.r, got_exp.ovf);
    end
  endtask

  task automatic check_c(input int r, input int d, input logic rst, input exp_t e);
    logic [6:0] got, exp_v;
    reset_c = rst; en_c = 1'b0; r_c = 3'(r); d_c = 3'(d);
    #1;
    got   = {ovf_c, q_c, rem_c};
    exp_v = {e.ovf, 3'(e.q), 3'(e.r)};
    n_cmp++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got q=%0d rem=%0d ovf=%0d, expected q=%0d rem=%0d ovf=%0d",
             e.tag, q_c, rem_c, ovf_c, e.q, e.r, e.ovf);
    end
  endtask

  initial begin
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; r_a = '0; d_a = '0; r_b = '0; d_b = '0;
    reset_c = 1'b0; en_c = 1'b0; r_c = '0; d_c = '0;
    last_a = mk(0, 0, 1'b0, "init");
    last_b = mk(0, 0, 1'b0, "init");
    @(posedge clock); #1;

    // Reset beats enable; outputs stay 0 until the first enabled edge
    step_a(1'b1, 1'b1, 4, 7, mk(0, 0, 1'b0, "reset_1"));
    step_a(1'b1, 1'b1, 4, 7, mk(0, 0, 1'b0, "reset_2"));
    step_a(1'b0, 1'b0, 4, 7, mk(0, 0, 1'b0, "post_reset_idle"));

    // Basic digits
    step_a(1'b0, 1'b1, 0, 7, mk(1, 2, 1'b0, "r0_d7"));
    step_a(1'b0, 1'b1, 2, 5, mk(4, 1, 1'b0, "r2_d5"));
    step_a(1'b0, 1'b1, 4, 7, mk(7, 4, 1'b0, "r4_d7"));

    // Overflow: N=63, Q=12
    step_a(1'b0, 1'b1, 7, 7, mk(4, 3, 1'b1, "ovf_r7_d7"));

    // Enable hold
    step_a(1'b0, 1'b1, 2, 5, mk(4, 1, 1'b0, "hold_load"));
    for (int i = 0; i < 3; i++)
      step_a(1'b0, 1'b0, 0, 1, mk(0, 0, 1'b0, $sformatf("hold_%0d", i)));

    // Exhaustive sweep, V=5 D=3
    for (int r = 0; r < 8; r++)
      for (int d = 0; d < 8; d++)
        step_a(1'b0, 1'b1, r, d, model(5, 3, r, d, $sformatf("sweepA_r%0d_d%0d", r, d)));
    en_a = 1'b0;

    // V=3 D=4 W=2 directed, then exhaustive
    step_b(1'b0, 1'b0, 0, 0, mk(0, 0, 1'b0, "B_post_reset"));
    step_b(1'b0, 1'b1, 2, 15, mk(15, 2, 1'b0, "B_r2_d15"));
    step_b(1'b0, 1'b1, 3, 15, mk(5, 0, 1'b1, "B_ovf_r3_d15"));
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 16; d++)
        step_b(1'b0, 1'b1, r, d, model(3, 4, r, d, $sformatf("sweepB_r%0d_d%0d", r, d)));
    step_b(1'b1, 1'b1, 1, 1, mk(0, 0, 1'b0, "B_reset"));

    // Combinational configuration ignores reset
    check_c(1, 3, 1'b0, mk(2, 1, 1'b0, "C_r1_d3"));
    check_c(1, 3, 1'b1, mk(2, 1, 1'b0, "C_r1_d3_reset"));
    check_c(7, 7, 1'b1, mk(4, 3, 1'b1, "C_ovf_r7_d7"));
    check_c(4, 2, 1'b0, mk(6, 4, 1'b0, "C_r4_d2"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
